// File: rtl/addmul_sgn_arbiter.sv
// addmul_sgn_arbiter: round-robin arbiter sharing one pipelined signed
// adder-multiplier P = (XS+XC)*Y between NumReq valid/ready requesters.
// Results leave in acceptance order on one valid/ready port, tagged with
// the index of the requester that issued them.
//
// Optional build macro ADDMUL_ARB_PERF_EN adds saturating 32-bit counters
// busy_cnt_o (accepted requests) and stall_cnt_o (output back-pressure cycles).
//
// Pipeline: the product is formed combinationally from the granted operands
// and then carried through Latency register stages; the last stage is the
// output register. The whole pipeline moves only when the output is empty or
// being consumed, so a stall freezes every stage at once and nothing is lost.
module addmul_sgn_arbiter #(
    parameter int BW      = 8,
    parameter int NumReq  = 4,
    parameter int Latency = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    output logic [NumReq-1:0]      req_ready_o,
    input  logic [NumReq*BW-1:0]   req_xs_i,
    input  logic [NumReq*BW-1:0]   req_xc_i,
    input  logic [NumReq*BW-1:0]   req_y_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [$clog2(NumReq)-1:0] rsp_id_o,
    output logic [2*BW-1:0]        rsp_p_o
`ifdef ADDMUL_ARB_PERF_EN
    ,
    output logic [31:0]            busy_cnt_o,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int IdW = $clog2(NumReq);
    localparam int PW  = 2 * BW;

    logic              adv;
    logic              accept;
    logic [NumReq-1:0] grant;
    logic              grant_any;
    logic [IdW-1:0]    grant_idx;
    logic [IdW-1:0]    ptr;
    logic [IdW:0]      cand_wide;
    logic [IdW-1:0]    cand;

    logic [BW-1:0]     xs_sel;
    logic [BW-1:0]     xc_sel;
    logic [BW-1:0]     y_sel;
    logic [BW-1:0]     sum_sel;
    logic [PW-1:0]     sum_ext;
    logic [PW-1:0]     y_ext;
    logic [PW-1:0]     prod;

    logic [Latency-1:0] st_valid;
    logic [IdW-1:0]     st_id [Latency];
    logic [PW-1:0]      st_p  [Latency];

    assign rsp_valid_o = st_valid[Latency-1];
    assign rsp_id_o    = st_id[Latency-1];
    assign rsp_p_o     = st_p[Latency-1];

    assign adv = !rsp_valid_o || rsp_ready_i;

    // Reset also gates ready so nothing is accepted in a reset cycle.
    assign req_ready_o = (adv && !rst_i) ? grant : '0;
    assign accept      = grant_any && adv && !rst_i;

    // Round-robin search starting at ptr, wrapping past NumReq-1 back to 0.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand_wide = {1'b0, ptr} + (IdW+1)'(k);
            if (cand_wide >= (IdW+1)'(NumReq)) begin
                cand_wide = cand_wide - (IdW+1)'(NumReq);
            end
            cand = cand_wide[IdW-1:0];
            if (!grant_any && req_valid_i[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Operand select for the granted requester and the signed datapath.
    // The sum wraps in BW bits before being sign-extended into the multiply.
    always_comb begin
        xs_sel  = req_xs_i[int'(grant_idx)*BW +: BW];
        xc_sel  = req_xc_i[int'(grant_idx)*BW +: BW];
        y_sel   = req_y_i[int'(grant_idx)*BW +: BW];
        sum_sel = xs_sel + xc_sel;
        sum_ext = {{BW{sum_sel[BW-1]}}, sum_sel};
        y_ext   = {{BW{y_sel[BW-1]}}, y_sel};
        prod    = sum_ext * y_ext;
    end

    // Round-robin pointer: moves just past the winner on every acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (accept) begin
            if (grant_idx == IdW'(NumReq-1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Result pipeline: shifts as a whole when adv, otherwise every stage holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_valid <= '0;
            for (int i = 0; i < Latency; i++) begin
                st_id[i] <= '0;
                st_p[i]  <= '0;
            end
        end else if (adv) begin
            st_valid[0] <= accept;
            st_id[0]    <= grant_idx;
            st_p[0]     <= prod;
            for (int i = 1; i < Latency; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_id[i]    <= st_id[i-1];
                st_p[i]     <= st_p[i-1];
            end
        end
    end

`ifdef ADDMUL_ARB_PERF_EN
    // Saturating activity counters: accepted requests and output stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (accept && (busy_cnt_o != 32'hFFFF_FFFF)) begin
                busy_cnt_o <= busy_cnt_o + 32'd1;
            end
            if (rsp_valid_o && !rsp_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addmul_sgn_arbiter.sv
// Directed testbench for addmul_sgn_arbiter (BW=8, NumReq=4, Latency=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_addmul_sgn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_xs;
    logic [31:0] req_xc;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_p;
`ifdef ADDMUL_ARB_PERF_EN
    logic [31:0] busy_cnt;
    logic [31:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addmul_sgn_arbiter #(.BW(8), .NumReq(4), .Latency(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_xs_i    (req_xs),
        .req_xc_i    (req_xc),
        .req_y_i     (req_y),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_p_o     (rsp_p)
`ifdef ADDMUL_ARB_PERF_EN
        ,
        .busy_cnt_o  (busy_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] xs, input logic [7:0] xc, input logic [7:0] y);
        req_xs[i*8 +: 8] = xs;
        req_xc[i*8 +: 8] = xc;
        req_y[i*8 +: 8]  = y;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        step(); step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        tests++; if (rsp_p !== 16'h0000) begin fails++; $display("FAIL reset_rsp_p got %h exp 0000", rsp_p); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        rst = 1'b0; req_valid = 4'h0;
        step();
    endtask

    task automatic test_single();
        set_op(0, 8'd5, 8'hFD, 8'hF9);
        req_valid = 4'b0001; #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000; #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %0b exp 0", rsp_valid); end
        step();
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", rsp_valid); end
        tests++; if (rsp_p !== 16'hFFF2) begin fails++; $display("FAIL single_p got %h exp fff2", rsp_p); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id got %0d exp 0", rsp_id); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drop got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_overflow();
        set_op(3, 8'd100, 8'd100, 8'd2);
        req_valid = 4'b1000; #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL ovf_ready got %b exp 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid got %0b exp 1", rsp_valid); end
        tests++; if (rsp_p !== 16'hFF90) begin fails++; $display("FAIL ovf_p got %h exp ff90", rsp_p); end
        tests++; if (rsp_id !== 2'd3) begin fails++; $display("FAIL ovf_id got %0d exp 3", rsp_id); end
        step();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd0, 8'd10);
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++; if (req_ready !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_ready k=%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
            if (k >= 2) begin
                tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rr_valid k=%0d got %0b exp 1", k, rsp_valid); end
                tests++; if (rsp_id !== 2'((k - 2) % 4)) begin fails++; $display("FAIL rr_id k=%0d got %0d exp %0d", k, rsp_id, (k - 2) % 4); end
                tests++; if (rsp_p !== 16'((((k - 2) % 4) + 1) * 10)) begin fails++; $display("FAIL rr_p k=%0d got %0d exp %0d", k, rsp_p, (((k - 2) % 4) + 1) * 10); end
            end
            step();
        end
        req_valid = 4'h0; #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rr_idle_ready got %b exp 0000", req_ready); end
        tests++; if (rsp_id !== 2'd2 || rsp_p !== 16'd30) begin fails++; $display("FAIL rr_tail6 got id %0d p %0d exp id 2 p 30", rsp_id, rsp_p); end
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== 16'd40) begin fails++; $display("FAIL rr_tail7 got v %0b id %0d p %0d exp v 1 id 3 p 40", rsp_valid, rsp_id, rsp_p); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_empty got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_stall();
        req_valid = 4'hF; rsp_ready = 1'b1; #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL stall_fill0 got %b exp 0001", req_ready); end
        step();
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stall_fill1 got %b exp 0010", req_ready); end
        step();
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready c=%0d got %b exp 0000", c, req_ready); end
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'd10) begin fails++; $display("FAIL stall_hold c=%0d got v %0b id %0d p %0d exp v 1 id 0 p 10", c, rsp_valid, rsp_id, rsp_p); end
            if (c < 3) step();
        end
        rsp_ready = 1'b1; #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL stall_release_ready got %b exp 0100", req_ready); end
        step();
        req_valid = 4'h0;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 16'd20) begin fails++; $display("FAIL stall_drain1 got v %0b id %0d p %0d exp v 1 id 1 p 20", rsp_valid, rsp_id, rsp_p); end
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 16'd30) begin fails++; $display("FAIL stall_drain2 got v %0b id %0d p %0d exp v 1 id 2 p 30", rsp_valid, rsp_id, rsp_p); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL stall_drained got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        set_op(0, 8'hFE, 8'hFE, 8'd3);
        rsp_ready = 1'b1;
        req_valid = 4'b0001; #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_acc0 got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0010; #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rmid_acc1 got %b exp 0010", req_ready); end
        step();
        req_valid = 4'b0000; rsp_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_flush_valid got %0b exp 0", rsp_valid); end
        tests++; if (rsp_id !== 2'd0 || rsp_p !== 16'd0) begin fails++; $display("FAIL rmid_flush_data got id %0d p %h exp id 0 p 0000", rsp_id, rsp_p); end
        req_valid = 4'b0101; rsp_ready = 1'b1; #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_ptr got %b exp 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_ghost got %0b exp 0", rsp_valid); end
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'hFFF4) begin fails++; $display("FAIL rmid_result got v %0b id %0d p %h exp v 1 id 0 p fff4", rsp_valid, rsp_id, rsp_p); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_single got %0b exp 0", rsp_valid); end
    endtask

`ifdef ADDMUL_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'b0001; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rsp_ready = 1'b1;
        step(); step(); step();
        tests++; if (busy_cnt !== 32'd10) begin fails++; $display("FAIL perf_busy got %0d exp 10", busy_cnt); end
        tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL perf_stall got %0d exp 3", stall_cnt); end
    endtask
`endif

    initial begin
        req_xs = '0; req_xc = '0; req_y = '0;
        req_valid = '0; rsp_ready = 1'b1; rst = 1'b1;
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_stall();
        test_reset_mid();
`ifdef ADDMUL_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
